// File: rtl/reloj_pkg.sv
// Shared constants for the clock mode/display controller:
// mode encodings, seven-segment glyphs and a counter-width helper.
package reloj_pkg;

  localparam logic [1:0] MODE_HORA      = 2'd0;
  localparam logic [1:0] MODE_AJ_HORA   = 2'd1;
  localparam logic [1:0] MODE_AJ_ALARMA = 2'd2;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_ZERO  = 7'b0000001;
  localparam logic [6:0] SEG_ONE   = 7'b1001111;

  function automatic int cnt_w(input int n);
    return $clog2((n < 2) ? 2 : n);
  endfunction

endpackage

// File: rtl/reloj_mode_ctrl_if.sv
// Button, source and display bundle for reloj_mode_ctrl.
// master: drives buttons/sources; slave: the controller.
interface reloj_mode_ctrl_if #(
  parameter int DIGITS = 4,
  parameter int SEG_W  = 7,
  parameter int N_SRC  = 3
);
  logic                            MODE_BTN;
  logic                            AUM;
  logic                            AUH;
  logic [N_SRC*DIGITS*SEG_W-1:0]   src_segs;
  logic [DIGITS*SEG_W-1:0]         disp;
  logic [1:0]                      modo;
  logic                            AJUSTH;
  logic                            AJUSTA;
  logic                            AUMM;
  logic                            AUMH;

  modport master (
    output MODE_BTN, AUM, AUH, src_segs,
    input  disp, modo, AJUSTH, AJUSTA, AUMM, AUMH
  );

  modport slave (
    input  MODE_BTN, AUM, AUH, src_segs,
    output disp, modo, AJUSTH, AJUSTA, AUMM, AUMH
  );
endinterface

// File: rtl/reloj_btn_repeat.sv
// Edge detect + hold-to-repeat for one increment button.
// Ports: CLK, RST, clr (cancel hold), btn (level), pulse (comb).
module reloj_btn_repeat
  import reloj_pkg::*;
#(
  parameter int REPEAT_DLY = 25_000_000,
  parameter int REPEAT_PER = 5_000_000
) (
  input  logic CLK,
  input  logic RST,
  input  logic clr,
  input  logic btn,
  output logic pulse
);
  localparam int MAXC =
    (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
  localparam int CW = cnt_w(MAXC);
  localparam logic [CW-1:0] DLY_T = CW'(REPEAT_DLY - 1);
  localparam logic [CW-1:0] PER_T = CW'(REPEAT_PER - 1);

  logic          prev;
  logic          act;
  logic          rep;
  logic [CW-1:0] cnt;
  logic          rise;
  logic          hit;

  assign rise  = btn & ~prev;
  // act drops on release or clr, so a cancelled hold
  // stays silent until the button is pressed again
  assign hit   = btn & act &
                 (cnt == (rep ? PER_T : DLY_T));
  assign pulse = rise | hit;

  always_ff @(posedge CLK) begin
    if (RST) begin
      prev <= 1'b0;
      act  <= 1'b0;
      rep  <= 1'b0;
      cnt  <= '0;
    end else begin
      prev <= btn;
      if (clr || !btn) begin
        act <= 1'b0;
        rep <= 1'b0;
        cnt <= '0;
      end else if (rise) begin
        act <= 1'b1;
        rep <= 1'b0;
        cnt <= '0;
      end else if (hit) begin
        rep <= 1'b1;
        cnt <= '0;
      end else if (act) begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

// File: rtl/reloj_mode_ctrl.sv
// Mode FSM, increment gating, source mux and adjust blink.
// Ports: CLK, RST, bus (slave side of reloj_mode_ctrl_if).
module reloj_mode_ctrl
  import reloj_pkg::*;
#(
  parameter int DIGITS     = 4,
  parameter int SEG_W      = 7,
  parameter int N_SRC      = 3,
  parameter int BLINK_HALF = 25_000_000,
  parameter int REPEAT_DLY = 25_000_000,
  parameter int REPEAT_PER = 5_000_000
) (
  input  logic                    CLK,
  input  logic                    RST,
  reloj_mode_ctrl_if.slave        bus
);
  localparam int DW = DIGITS * SEG_W;
  localparam int BW = cnt_w(BLINK_HALF);
  localparam logic [BW-1:0] BT = BW'(BLINK_HALF - 1);

  logic          mprev;
  logic          adv;
  logic [1:0]    modo_q;
  logic [1:0]    modo_n;
  logic          raw_m;
  logic          raw_h;
  logic          gate;
  logic          fire_m;
  logic          fire_h;
  logic          phase;
  logic [BW-1:0] bcnt;
  logic [DW-1:0] sel;
  logic [DW-1:0] rst_pat;
  logic [DW-1:0] disp_q;
  logic          ajh_q;
  logic          aja_q;
  logic          aumm_q;
  logic          aumh_q;

  assign adv = bus.MODE_BTN & ~mprev;

  always_comb begin
    modo_n = MODE_HORA;
    unique case (1'b1)
      (modo_q == MODE_HORA):
        modo_n = adv ? MODE_AJ_HORA : MODE_HORA;
      (modo_q == MODE_AJ_HORA):
        modo_n = adv ? MODE_AJ_ALARMA : MODE_AJ_HORA;
      (modo_q == MODE_AJ_ALARMA):
        modo_n = adv ? MODE_HORA : MODE_AJ_ALARMA;
      default:
        modo_n = MODE_HORA;
    endcase
  end

  reloj_btn_repeat #(
    .REPEAT_DLY(REPEAT_DLY),
    .REPEAT_PER(REPEAT_PER)
  ) u_rep_m (
    .CLK(CLK), .RST(RST), .clr(adv),
    .btn(bus.AUM), .pulse(raw_m)
  );

  reloj_btn_repeat #(
    .REPEAT_DLY(REPEAT_DLY),
    .REPEAT_PER(REPEAT_PER)
  ) u_rep_h (
    .CLK(CLK), .RST(RST), .clr(adv),
    .btn(bus.AUH), .pulse(raw_h)
  );

  assign gate   = (modo_q != MODE_HORA) & ~adv;
  assign fire_m = raw_m & gate;
  assign fire_h = raw_h & gate;

  // only sources 0..2 are reachable; encoding 3 shows source 0
  always_comb begin
    sel = bus.src_segs[0 +: DW];
    for (int s = 1; s < 3; s++) begin
      if (modo_q == 2'(s)) sel = bus.src_segs[s*DW +: DW];
    end
  end

  always_comb begin
    rst_pat = '0;
    for (int d = 0; d < DIGITS; d++) begin
      rst_pat[d*SEG_W +: SEG_W] =
        (d == 3) ? SEG_W'(SEG_ONE) : SEG_W'(SEG_ZERO);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      modo_q <= MODE_HORA;
      mprev  <= 1'b0;
      ajh_q  <= 1'b0;
      aja_q  <= 1'b0;
      aumm_q <= 1'b0;
      aumh_q <= 1'b0;
      phase  <= 1'b1;
      bcnt   <= '0;
      disp_q <= rst_pat;
    end else begin
      mprev  <= bus.MODE_BTN;
      modo_q <= modo_n;
      ajh_q  <= (modo_n == MODE_AJ_HORA);
      aja_q  <= (modo_n == MODE_AJ_ALARMA);
      aumm_q <= fire_m;
      aumh_q <= fire_h;
      disp_q <= phase ? sel : {DIGITS{SEG_W'(SEG_BLANK)}};
      // stepping or entering a mode restarts the on phase
      if (modo_q == MODE_HORA || adv || fire_m || fire_h) begin
        phase <= 1'b1;
        bcnt  <= '0;
      end else if (bcnt == BT) begin
        phase <= ~phase;
        bcnt  <= '0;
      end else begin
        bcnt <= bcnt + 1'b1;
      end
    end
  end

  assign bus.disp   = disp_q;
  assign bus.modo   = modo_q;
  assign bus.AJUSTH = ajh_q;
  assign bus.AJUSTA = aja_q;
  assign bus.AUMM   = aumm_q;
  assign bus.AUMH   = aumh_q;
endmodule

// File: tb/tb_reloj_mode_ctrl.sv
// Scoreboard bench for reloj_mode_ctrl: driver pushes model
// expectations, a monitor pops and compares after each edge.
module tb_reloj_mode_ctrl;
  localparam int DIGITS = 4;
  localparam int SEG_W  = 7;
  localparam int N_SRC  = 3;
  localparam int BH     = 8;
  localparam int RD     = 10;
  localparam int RP     = 4;
  localparam int DW     = DIGITS * SEG_W;
  localparam int SW     = N_SRC * DW;

  typedef struct packed {
    logic [1:0]    modo;
    logic          ajh;
    logic          aja;
    logic          aumm;
    logic          aumh;
    logic [DW-1:0] disp;
  } obs_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  reloj_mode_ctrl_if #(
    .DIGITS(DIGITS), .SEG_W(SEG_W), .N_SRC(N_SRC)
  ) bus ();

  reloj_mode_ctrl #(
    .DIGITS(DIGITS), .SEG_W(SEG_W), .N_SRC(N_SRC),
    .BLINK_HALF(BH), .REPEAT_DLY(RD), .REPEAT_PER(RP)
  ) dut (
    .CLK(clk), .RST(rst), .bus(bus.slave)
  );

  obs_t expq[$];
  int   errors = 0;
  int   checks = 0;
  int   ncyc   = 0;

  // reference model state
  int m     = 0;
  int since = 0;
  bit mprev = 0;
  bit bprev [2];
  bit act   [2];
  int held  [2];

  function automatic logic [SW-1:0] rsrc();
    logic [95:0] t;
    t = {$urandom(), $urandom(), $urandom()};
    return t[SW-1:0];
  endfunction

  task automatic cyc(input bit r, input bit mb,
                     input bit a, input bit h,
                     input logic [SW-1:0] src);
    obs_t e;
    bit   adv;
    bit   b    [2];
    bit   raw  [2];
    bit   fire [2];
    bit   on;
    @(negedge clk);
    rst          = r;
    bus.MODE_BTN = mb;
    bus.AUM      = a;
    bus.AUH      = h;
    bus.src_segs = src;
    b[0] = a;
    b[1] = h;
    e = '0;
    if (r) begin
      m = 0; mprev = 0; since = 0;
      for (int i = 0; i < 2; i++) begin
        bprev[i] = 0; act[i] = 0; held[i] = 0;
      end
      e.disp = {7'b1001111, 7'b0000001,
                7'b0000001, 7'b0000001};
    end else begin
      adv = mb && !mprev;
      for (int i = 0; i < 2; i++) begin
        raw[i] = 0;
        if (b[i] && !bprev[i]) begin
          raw[i] = 1; act[i] = 1; held[i] = 0;
        end else if (b[i] && act[i]) begin
          held[i]++;
          raw[i] = (held[i] >= RD) &&
                   ((held[i] - RD) % RP == 0);
        end
        if (!b[i] || adv) act[i] = 0;
        bprev[i] = b[i];
        fire[i]  = raw[i] && (m != 0) && !adv;
      end
      on = ((since / BH) % 2) == 0;
      e.disp = on ? src[m*DW +: DW] : {DW{1'b1}};
      if (m == 0 || adv || fire[0] || fire[1]) since = 0;
      else since++;
      if (adv) m = (m + 1) % 3;
      mprev  = mb;
      e.aumm = fire[0];
      e.aumh = fire[1];
    end
    e.modo = 2'(m);
    e.ajh  = (m == 1);
    e.aja  = (m == 2);
    expq.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, rsrc());
  endtask

  task automatic press_mode();
    cyc(0, 1, 0, 0, rsrc());
    idle(3);
  endtask

  initial begin : monitor
    obs_t e;
    obs_t g;
    forever begin
      @(posedge clk);
      #1;
      ncyc++;
      if (expq.size() > 0) begin
        e = expq.pop_front();
        g = {bus.modo, bus.AJUSTH, bus.AJUSTA,
             bus.AUMM, bus.AUMH, bus.disp};
        checks++;
        if (g !== e) begin
          errors++;
          $display("FAIL outputs @%0d: got modo=%0d ah=%b aa=%b m=%b h=%b disp=%h, exp modo=%0d ah=%b aa=%b m=%b h=%b disp=%h",
                   ncyc, g.modo, g.ajh, g.aja, g.aumm, g.aumh,
                   g.disp, e.modo, e.ajh, e.aja, e.aumm,
                   e.aumh, e.disp);
        end
      end
    end
  end

  initial begin : driver
    logic [SW-1:0] fix;
    bit rmb, ra, rh, rr;
    bus.MODE_BTN = 0;
    bus.AUM      = 0;
    bus.AUH      = 0;
    bus.src_segs = '0;
    fix = rsrc();
    fix[DW-1:0] = {7'h78, 7'h56, 7'h34, 7'h12};

    // reset hold and release
    repeat (3) cyc(1, 0, 0, 0, fix);
    repeat (2) cyc(0, 0, 0, 0, fix);

    // full mode cycle
    repeat (3) begin
      cyc(0, 1, 0, 0, rsrc());
      idle(4);
    end

    // increments ignored in HORA
    repeat (30) cyc(0, 0, 1, 0, rsrc());
    idle(1);

    // auto-repeat in AJ_HORA
    press_mode();
    repeat (25) cyc(0, 0, 0, 1, rsrc());
    idle(6);

    // blink in AJ_ALARMA, then back to HORA
    press_mode();
    idle(40);
    press_mode();

    // mode advance colliding with an increment edge
    press_mode();
    cyc(0, 1, 1, 0, rsrc());
    repeat (2) cyc(0, 0, 1, 0, rsrc());
    idle(2);

    // reset in the middle of a repeat run
    repeat (16) cyc(0, 0, 1, 0, rsrc());
    repeat (2) cyc(1, 0, 1, 0, rsrc());
    repeat (5) cyc(0, 0, 1, 0, rsrc());
    idle(2);

    // randomized traffic
    rmb = 0; ra = 0; rh = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0) rmb = !rmb;
      if ($urandom_range(0, 7) == 0)  ra  = !ra;
      if ($urandom_range(0, 7) == 0)  rh  = !rh;
      rr = ($urandom_range(0, 399) == 0);
      cyc(rr, rmb, ra, rh, rsrc());
    end
    idle(1);

    repeat (3) @(negedge clk);
    checks++;
    if (expq.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d left, required 0",
               expq.size());
    end
    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end
endmodule
